// File: rtl/debouncer_pkg.sv
// Shared constants for the multi-channel debouncer: FSM state encoding and
// the synchronizer depth that applies when DEBOUNCER_SYNC_EN is defined.
package debouncer_pkg;

   typedef enum logic [1:0] {
      LOW    = 2'b00,
      WAIT_H = 2'b01,
      HIGH   = 2'b10,
      WAIT_L = 2'b11
   } state_e;

   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/debouncer_channel.sv
// One debounce channel: delayed-debounce FSM with a tick-gated timer and registered
// rise/fall pulses. Defining DEBOUNCER_SYNC_EN adds a 2-flop input synchronizer.
module debouncer_channel
   import debouncer_pkg::*;
#(
   parameter int unsigned CNT_W          = 20,
   parameter int unsigned DEBOUNCE_TICKS = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic noisy,
   output logic debounced,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_TICKS - 1);

   logic s;

`ifdef DEBOUNCER_SYNC_EN
   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];
`else
   assign s = noisy;
`endif

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             debounced_q;
   logic             rise_q;
   logic             fall_q;
   logic             busy_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= LOW;
         cnt_q       <= '0;
         debounced_q <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_q)
            LOW: begin
               cnt_q       <= '0;
               debounced_q <= 1'b0;
               if (s) begin
                  state_q <= WAIT_H;
                  busy_q  <= 1'b1;
               end
            end
            WAIT_H: begin
               if (!s) begin
                  state_q <= LOW;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (tick && cnt_q == TERM) begin
                  state_q     <= HIGH;
                  cnt_q       <= '0;
                  busy_q      <= 1'b0;
                  debounced_q <= 1'b1;
                  rise_q      <= 1'b1;
               end else if (tick) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HIGH: begin
               cnt_q       <= '0;
               debounced_q <= 1'b1;
               if (!s) begin
                  state_q <= WAIT_L;
                  busy_q  <= 1'b1;
               end
            end
            WAIT_L: begin
               if (s) begin
                  state_q <= HIGH;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (tick && cnt_q == TERM) begin
                  state_q     <= LOW;
                  cnt_q       <= '0;
                  busy_q      <= 1'b0;
                  debounced_q <= 1'b0;
                  fall_q      <= 1'b1;
               end else if (tick) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q     <= LOW;
               cnt_q       <= '0;
               debounced_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign debounced = debounced_q;
   assign rise      = rise_q;
   assign fall      = fall_q;
   assign busy      = busy_q;

endmodule

// File: rtl/debouncer_multi_ch.sv
// CH_NUM independent debounce channels sharing one timer tick.
// Define DEBOUNCER_SYNC_EN to add a 2-flop synchronizer on every noisy input.
module debouncer_multi_ch #(
   parameter int unsigned CH_NUM         = 4,
   parameter int unsigned CNT_W          = 20,
   parameter int unsigned DEBOUNCE_TICKS = 1000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick,
   input  logic [CH_NUM-1:0] noisy,
   output logic [CH_NUM-1:0] debounced,
   output logic [CH_NUM-1:0] rise,
   output logic [CH_NUM-1:0] fall,
   output logic [CH_NUM-1:0] busy
);

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      debouncer_channel #(
         .CNT_W          (CNT_W),
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
      ) u_ch (
         .clk       (clk),
         .reset_n   (reset_n),
         .tick      (tick),
         .noisy     (noisy[i]),
         .debounced (debounced[i]),
         .rise      (rise[i]),
         .fall      (fall[i]),
         .busy      (busy[i])
      );
   end

endmodule

// File: tb/tb_debouncer_multi_ch.sv
// Scoreboard bench for debouncer_multi_ch: a per-channel reference model pushes
// expected outputs on each rising edge; they are popped and compared on the falling edge.
module tb_debouncer_multi_ch;

   localparam int DT = 4;
`ifdef DEBOUNCER_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   localparam int LAT = DT + 1 + SYNC_LAT;

   typedef struct packed {
      logic [3:0] deb;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] busy;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tick;
   logic [3:0] noisy;
   logic [3:0] debounced;
   logic [3:0] rise;
   logic [3:0] fall;
   logic [3:0] busy;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc_cnt = 0;
   exp_t sb[$];

   debouncer_multi_ch #(
      .CH_NUM         (4),
      .CNT_W          (8),
      .DEBOUNCE_TICKS (DT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .noisy     (noisy),
      .debounced (debounced),
      .rise      (rise),
      .fall      (fall),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc_cnt, got, exp);
      end
   endtask

   // Reference model: accepted level plus a pending flag and a count of ticks seen
   // while the input has continuously disagreed with the accepted level.
   logic [3:0] m_lvl = '0;
   logic [3:0] m_pend = '0;
   int         m_ticks[4];
   logic [3:0] m_sync1 = '0;
   logic [3:0] m_sync2 = '0;

   always @(posedge clk) begin
      exp_t       e;
      logic [3:0] s;
      cyc_cnt++;
`ifdef DEBOUNCER_SYNC_EN
      s = m_sync2;
      if (!reset_n) begin
         m_sync2 = '0;
         m_sync1 = '0;
      end else begin
         m_sync2 = m_sync1;
         m_sync1 = noisy;
      end
`else
      s = noisy;
`endif
      e.rise = '0;
      e.fall = '0;
      if (!reset_n) begin
         m_lvl  = '0;
         m_pend = '0;
         for (int c = 0; c < 4; c++) m_ticks[c] = 0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (s[c] != m_lvl[c]) begin
               if (!m_pend[c]) begin
                  m_pend[c]  = 1'b1;
                  m_ticks[c] = 0;
               end else if (tick) begin
                  m_ticks[c]++;
                  if (m_ticks[c] == DT) begin
                     m_lvl[c]  = s[c];
                     m_pend[c] = 1'b0;
                     if (s[c]) e.rise[c] = 1'b1;
                     else      e.fall[c] = 1'b1;
                  end
               end
            end else begin
               m_pend[c] = 1'b0;
            end
         end
      end
      e.deb  = m_lvl;
      e.busy = m_pend;
      sb.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq("debounced", 32'(debounced), 32'(e.deb));
         check_eq("rise", 32'(rise), 32'(e.rise));
         check_eq("fall", 32'(fall), 32'(e.fall));
         check_eq("busy", 32'(busy), 32'(e.busy));
      end
   end

   task automatic step(input logic [3:0] n, input logic t, input logic r);
      @(negedge clk);
      noisy   = n;
      tick    = t;
      reset_n = r;
   endtask

   // Cycles from the drive cycle `start` until the selected pulse appears on channel ch.
   task automatic measure(input string tag, input int ch, input bit want_fall, input int start);
      int lat;
      lat = -1;
      for (int i = 0; i < 40 && lat < 0; i++) begin
         @(negedge clk);
         if ((want_fall ? fall[ch] : rise[ch]) == 1'b1) lat = cyc_cnt - start;
      end
      check_eq(tag, 32'(lat), 32'(LAT));
   endtask

   initial begin
      int start;
      int got;
      reset_n = 1'b0;
      tick    = 1'b1;
      noisy   = 4'hF;

      // Reset held with all inputs high
      for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 1'b0);
      check_eq("rst_deb", 32'(debounced), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      for (int i = 0; i < 4; i++) step(4'h0, 1'b1, 1'b1);

      // Clean press on ch0
      step(4'b0001, 1'b1, 1'b1);
      start = cyc_cnt;
      measure("press_lat", 0, 1'b0, start);
      check_eq("press_deb", 32'(debounced[0]), 32'h1);

      // Bounce on ch1, then steady high
      step(4'b0011, 1'b1, 1'b1);
      step(4'b0001, 1'b1, 1'b1);
      step(4'b0011, 1'b1, 1'b1);
      step(4'b0011, 1'b1, 1'b1);
      step(4'b0001, 1'b1, 1'b1);
      step(4'b0011, 1'b1, 1'b1);
      start = cyc_cnt;
      measure("bounce_lat", 1, 1'b0, start);

      // Release ch0 with a one-cycle glitch back high
      step(4'b0010, 1'b1, 1'b1);
      step(4'b0010, 1'b1, 1'b1);
      step(4'b0011, 1'b1, 1'b1);
      step(4'b0010, 1'b1, 1'b1);
      start = cyc_cnt;
      measure("release_lat", 0, 1'b1, start);

      // Tick every third clock on ch2
      for (int i = 0; i < 21; i++) step(4'b0110, (i % 3) == 0, 1'b1);
      check_eq("tick_hi", 32'(debounced[2]), 32'h1);
      for (int i = 0; i < 24; i++) begin
         if (i == 4) step(4'b0110, 1'b0, 1'b1);
         else        step(4'b0010, (i % 3) == 0, 1'b1);
      end
      check_eq("tick_lo", 32'(debounced[2]), 32'h0);

      // All channels together
      for (int i = 0; i < 8; i++) step(4'h0, 1'b1, 1'b1);
      step(4'hF, 1'b1, 1'b1);
      start = cyc_cnt;
      got = -1;
      for (int i = 0; i < 40 && got < 0; i++) begin
         @(negedge clk);
         if (rise != 4'h0) begin
            got = cyc_cnt - start;
            check_eq("multi_rise_mask", 32'(rise), 32'hF);
         end
      end
      check_eq("multi_lat", 32'(got), 32'(LAT));

      // Reset pulse mid-wait aborts the count
      for (int i = 0; i < 8; i++) step(4'h0, 1'b1, 1'b1);
      step(4'hF, 1'b1, 1'b1);
      step(4'hF, 1'b1, 1'b1);
      step(4'hF, 1'b1, 1'b1);
      step(4'hF, 1'b1, 1'b0);
      step(4'hF, 1'b1, 1'b1);
      check_eq("midrst_busy", 32'(busy), 32'h0);
      check_eq("midrst_rise", 32'(rise), 32'h0);
      for (int i = 0; i < 12; i++) step(4'hF, 1'b1, 1'b1);
      check_eq("final_deb", 32'(debounced), 32'hF);

      step(4'hF, 1'b1, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
